// File: rtl/local_ni.sv
// Local network interface: buffers core flits toward the router local input
// (stamping the valid bit and an XY productive vector), and buffers flits
// ejected by the router toward the core. Ejected flits that arrive while the
// ejection buffer is full are dropped and counted.
module local_ni #(
  parameter int WIDTH_PORT = 64,
  parameter int WIDTH_PV   = 5,
  parameter int POS_VALID  = 63,
  parameter int POS_X_LSB  = 0,
  parameter int POS_Y_LSB  = 3,
  parameter int CORD_X     = 0,
  parameter int CORD_Y     = 0,
  parameter int INJ_DEPTH  = 4,
  parameter int EJ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inj_valid,
  input  logic [WIDTH_PORT-1:0] inj_data,
  output logic                  inj_ready,
  input  logic [3:0]            link_vld,
  output logic [WIDTH_PORT-1:0] dinLocal,
  output logic [WIDTH_PV-1:0]   PVLocal,
  input  logic [WIDTH_PORT-1:0] doutLocal,
  output logic                  ej_valid,
  output logic [WIDTH_PORT-1:0] ej_data,
  input  logic                  ej_ready,
  output logic                  ej_drop,
  output logic [7:0]            drop_cnt
);

  localparam int IAW = (INJ_DEPTH > 1) ? $clog2(INJ_DEPTH) : 1;
  localparam int ICW = $clog2(INJ_DEPTH) + 1;
  localparam int EAW = (EJ_DEPTH > 1) ? $clog2(EJ_DEPTH) : 1;
  localparam int ECW = $clog2(EJ_DEPTH) + 1;

  logic [WIDTH_PORT-1:0] r_inj_mem [INJ_DEPTH];
  logic [IAW-1:0]        r_inj_wr, r_inj_rd;
  logic [ICW-1:0]        r_inj_cnt;
  logic                  r_inj_ready;
  logic [WIDTH_PORT-1:0] r_din;
  logic [WIDTH_PV-1:0]   r_pv;

  logic [WIDTH_PORT-1:0] r_ej_mem [EJ_DEPTH];
  logic [EAW-1:0]        r_ej_wr, r_ej_rd;
  logic [ECW-1:0]        r_ej_cnt;
  logic                  r_ej_drop;
  logic [7:0]            r_drop_cnt;

  logic                  w_inj_push, w_inj_pop;
  logic [ICW-1:0]        w_inj_cnt_nxt;
  logic [WIDTH_PORT-1:0] w_inj_head;
  logic [2:0]            w_dst_x, w_dst_y;
  logic [WIDTH_PV-1:0]   w_pv;
  logic                  w_ej_arr, w_ej_pop, w_ej_full, w_ej_push, w_ej_drop;

  // Injection/ejection handshakes and the XY route of the injection head.
  always_comb begin
    w_inj_push    = inj_valid && r_inj_ready;
    w_inj_pop     = (r_inj_cnt != '0) && (link_vld != 4'b1111);
    w_inj_cnt_nxt = r_inj_cnt + ICW'(w_inj_push) - ICW'(w_inj_pop);
    w_inj_head    = r_inj_mem[r_inj_rd];
    w_dst_x       = w_inj_head[POS_X_LSB +: 3];
    w_dst_y       = w_inj_head[POS_Y_LSB +: 3];
    w_pv          = '0;
    if (w_dst_x > 3'(CORD_X))      w_pv[1] = 1'b1;
    else if (w_dst_x < 3'(CORD_X)) w_pv[3] = 1'b1;
    else if (w_dst_y > 3'(CORD_Y)) w_pv[0] = 1'b1;
    else if (w_dst_y < 3'(CORD_Y)) w_pv[2] = 1'b1;
    else                           w_pv[4] = 1'b1;
    w_ej_arr  = doutLocal[POS_VALID];
    w_ej_pop  = (r_ej_cnt != '0) && ej_ready;
    w_ej_full = (r_ej_cnt == ECW'(EJ_DEPTH));
    w_ej_push = w_ej_arr && (!w_ej_full || w_ej_pop);
    w_ej_drop = w_ej_arr && w_ej_full && !w_ej_pop;
  end

  // Buffer storage; contents are don't-care while the occupancy is zero.
  always_ff @(posedge clk) begin
    if (reset && w_inj_push) r_inj_mem[r_inj_wr] <= inj_data;
    if (reset && w_ej_push)  r_ej_mem[r_ej_wr]   <= doutLocal;
  end

  // Injection pointers, occupancy, registered ready and router-side outputs.
  // inj_ready is registered from the next occupancy so it has no input path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inj_wr    <= '0;
      r_inj_rd    <= '0;
      r_inj_cnt   <= '0;
      r_inj_ready <= 1'b0;
      r_din       <= '0;
      r_pv        <= '0;
    end else begin
      if (w_inj_push)
        r_inj_wr <= (r_inj_wr == IAW'(INJ_DEPTH - 1)) ? '0 : r_inj_wr + IAW'(1);
      if (w_inj_pop)
        r_inj_rd <= (r_inj_rd == IAW'(INJ_DEPTH - 1)) ? '0 : r_inj_rd + IAW'(1);
      r_inj_cnt   <= w_inj_cnt_nxt;
      r_inj_ready <= (w_inj_cnt_nxt != ICW'(INJ_DEPTH));
      if (w_inj_pop) begin
        r_din            <= w_inj_head;
        r_din[POS_VALID] <= 1'b1;
        r_pv             <= w_pv;
      end else begin
        r_din <= '0;
        r_pv  <= '0;
      end
    end
  end

  // Ejection pointers, occupancy, drop pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ej_wr    <= '0;
      r_ej_rd    <= '0;
      r_ej_cnt   <= '0;
      r_ej_drop  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_ej_push)
        r_ej_wr <= (r_ej_wr == EAW'(EJ_DEPTH - 1)) ? '0 : r_ej_wr + EAW'(1);
      if (w_ej_pop)
        r_ej_rd <= (r_ej_rd == EAW'(EJ_DEPTH - 1)) ? '0 : r_ej_rd + EAW'(1);
      r_ej_cnt  <= r_ej_cnt + ECW'(w_ej_push) - ECW'(w_ej_pop);
      r_ej_drop <= w_ej_drop;
      if (w_ej_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign inj_ready = r_inj_ready;
  assign dinLocal  = r_din;
  assign PVLocal   = r_pv;
  assign ej_valid  = (r_ej_cnt != '0);
  assign ej_data   = r_ej_mem[r_ej_rd];
  assign ej_drop   = r_ej_drop;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_local_ni.sv
// Bench for local_ni: a queue-based model of both buffers checked every cycle,
// plus literal expectations for the directed scenarios. A second instance at
// coordinate (3,3) covers the remaining XY directions.
module tb_local_ni;

  logic        clk = 1'b0;
  logic        reset;
  logic        inj_valid;
  logic [63:0] inj_data;
  logic        inj_ready;
  logic [3:0]  link_vld;
  logic [63:0] dinLocal;
  logic [4:0]  PVLocal;
  logic [63:0] doutLocal;
  logic        ej_valid;
  logic [63:0] ej_data;
  logic        ej_ready;
  logic        ej_drop;
  logic [7:0]  drop_cnt;

  logic        b_inj_valid;
  logic [63:0] b_inj_data;
  logic        b_inj_ready;
  logic [63:0] b_din;
  logic [4:0]  b_pv;
  logic        b_ej_valid;
  logic [63:0] b_ej_data;
  logic        b_ej_drop;
  logic [7:0]  b_drop_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  local_ni dut (
    .clk(clk), .reset(reset), .inj_valid(inj_valid), .inj_data(inj_data),
    .inj_ready(inj_ready), .link_vld(link_vld), .dinLocal(dinLocal),
    .PVLocal(PVLocal), .doutLocal(doutLocal), .ej_valid(ej_valid),
    .ej_data(ej_data), .ej_ready(ej_ready), .ej_drop(ej_drop),
    .drop_cnt(drop_cnt)
  );

  local_ni #(.CORD_X(3), .CORD_Y(3)) dut_b (
    .clk(clk), .reset(reset), .inj_valid(b_inj_valid), .inj_data(b_inj_data),
    .inj_ready(b_inj_ready), .link_vld(4'b0000), .dinLocal(b_din),
    .PVLocal(b_pv), .doutLocal(64'd0), .ej_valid(b_ej_valid),
    .ej_data(b_ej_data), .ej_ready(1'b0), .ej_drop(b_ej_drop),
    .drop_cnt(b_drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // XY routing rule: E/W on X first, then N/S on Y, else local.
  function automatic logic [4:0] xy(input logic [63:0] f, input int cx, input int cy);
    int x = int'(f[2:0]);
    int y = int'(f[5:3]);
    if (x > cx) return 5'b00010;
    if (x < cx) return 5'b01000;
    if (y > cy) return 5'b00001;
    if (y < cy) return 5'b00100;
    return 5'b10000;
  endfunction

  // Model state
  logic [63:0] iq[$];
  logic [63:0] eq[$];
  logic [63:0] m_din;
  logic [4:0]  m_pv;
  logic        m_drop;
  int          m_cnt;
  logic        m_rdy;
  logic        m_live = 1'b0;
  logic        pop_i, pop_e, arr;
  logic [63:0] h;

  // Model: advance both buffers from the inputs seen at this edge.
  always @(posedge clk) begin
    if (!reset) begin
      iq.delete(); eq.delete();
      m_din = '0; m_pv = '0; m_drop = 1'b0; m_cnt = 0; m_rdy = 1'b0; m_live = 1'b1;
    end else begin
      pop_i = (iq.size() > 0) && (link_vld != 4'b1111);
      if (pop_i) begin
        h = iq.pop_front();
        m_din = h; m_din[63] = 1'b1; m_pv = xy(h, 0, 0);
      end else begin
        m_din = '0; m_pv = '0;
      end
      if (inj_valid && m_rdy) iq.push_back(inj_data);
      m_rdy = (iq.size() < 4);
      pop_e  = (eq.size() > 0) && ej_ready;
      arr    = doutLocal[63];
      m_drop = arr && (eq.size() == 4) && !pop_e;
      if (pop_e) void'(eq.pop_front());
      if (arr && !m_drop) eq.push_back(doutLocal);
      if (m_drop && m_cnt != 255) m_cnt++;
    end
  end

  // Compare DUT against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (m_live) begin
      check("inj_ready", {63'd0, inj_ready}, {63'd0, m_rdy});
      check("dinLocal", dinLocal, m_din);
      check("PVLocal", {59'd0, PVLocal}, {59'd0, m_pv});
      check("ej_valid", {63'd0, ej_valid}, {63'd0, eq.size() != 0});
      if (eq.size() != 0) check("ej_data", ej_data, eq[0]);
      check("ej_drop", {63'd0, ej_drop}, {63'd0, m_drop});
      check("drop_cnt", {56'd0, drop_cnt}, 64'(m_cnt));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [63:0] b_dst [5];
  logic [4:0]  b_exp [5];

  initial begin
    reset = 1'b0; inj_valid = 1'b0; inj_data = '0; link_vld = 4'b0000;
    doutLocal = '0; ej_ready = 1'b0; b_inj_valid = 1'b0; b_inj_data = '0;
    tick(2);
    check("rst_din", dinLocal, 64'd0);
    check("rst_ready", {63'd0, inj_ready}, 64'd0);
    check("rst_ejvalid", {63'd0, ej_valid}, 64'd0);
    check("rst_dropcnt", {56'd0, drop_cnt}, 64'd0);
    reset = 1'b1;
    tick(1);

    // Single injection to (2,1)
    inj_valid = 1'b1; inj_data = 64'h0000_0000_0000_000A;
    tick(1);
    inj_valid = 1'b0;
    tick(1);
    check("single_din", dinLocal, 64'h8000_0000_0000_000A);
    check("single_pv", {59'd0, PVLocal}, 64'h02);
    tick(1);
    check("single_clear", dinLocal, 64'd0);

    // Blocked slots: four pushes, FIFO fills, then in-order drain
    link_vld = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      inj_valid = 1'b1; inj_data = 64'h100 + 64'(i) * 64'h40;
      tick(1);
    end
    inj_valid = 1'b0;
    check("full_ready", {63'd0, inj_ready}, 64'd0);
    tick(1);
    check("blocked_din", dinLocal, 64'd0);
    link_vld = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("drain_din", dinLocal, 64'h8000_0000_0000_0100 + 64'(i) * 64'h40);
    end
    link_vld = 4'b0000;
    tick(1);

    // XY on (0,0): N and local
    inj_valid = 1'b1; inj_data = 64'h18; tick(1);
    inj_data = 64'h00; tick(1);
    check("xy_n", {59'd0, PVLocal}, 64'h01);
    inj_valid = 1'b0; tick(1);
    check("xy_local", {59'd0, PVLocal}, 64'h10);
    tick(1);

    // XY on (3,3): N, local, S, W, E
    b_dst[0] = 64'h2B; b_exp[0] = 5'b00001;
    b_dst[1] = 64'h1B; b_exp[1] = 5'b10000;
    b_dst[2] = 64'h0B; b_exp[2] = 5'b00100;
    b_dst[3] = 64'h19; b_exp[3] = 5'b01000;
    b_dst[4] = 64'h1D; b_exp[4] = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      b_inj_valid = 1'b1; b_inj_data = b_dst[i];
      tick(1);
      b_inj_valid = 1'b0;
      tick(1);
      check("xyb_pv", {59'd0, b_pv}, {59'd0, b_exp[i]});
      check("xyb_din", b_din, b_dst[i] | 64'h8000_0000_0000_0000);
    end

    // Ejection overflow: six arrivals, four kept, two dropped
    ej_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      doutLocal = 64'h8000_0000_0000_0001 + 64'(i);
      tick(1);
    end
    doutLocal = '0;
    check("ovf_drop", {63'd0, ej_drop}, 64'd1);
    check("ovf_cnt", {56'd0, drop_cnt}, 64'd2);
    check("ovf_head", ej_data, 64'h8000_0000_0000_0001);
    tick(1);
    check("ovf_drop_end", {63'd0, ej_drop}, 64'd0);
    // Full with simultaneous pop and arrival
    ej_ready = 1'b1; doutLocal = 64'h8000_0000_0000_0077;
    tick(1);
    doutLocal = '0; ej_ready = 1'b0;
    check("fullpop_drop", {63'd0, ej_drop}, 64'd0);
    check("fullpop_cnt", {56'd0, drop_cnt}, 64'd2);
    check("fullpop_head", ej_data, 64'h8000_0000_0000_0002);
    ej_ready = 1'b1;
    tick(5);
    ej_ready = 1'b0;

    // Saturation: 4 stored then 300 drops on top of the existing 2
    for (int i = 0; i < 304; i++) begin
      doutLocal = 64'h8000_0000_0000_1000 + 64'(i);
      tick(1);
    end
    doutLocal = '0;
    check("sat_cnt", {56'd0, drop_cnt}, 64'd255);
    ej_ready = 1'b1;
    tick(5);
    ej_ready = 1'b0;

    // Reset with three flits queued in each FIFO
    link_vld = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      inj_valid = 1'b1; inj_data = 64'h200 + 64'(i);
      doutLocal = 64'h8000_0000_0000_0300 + 64'(i);
      tick(1);
    end
    doutLocal = '0;
    reset = 1'b0;
    tick(1);
    check("mid_din", dinLocal, 64'd0);
    check("mid_pv", {59'd0, PVLocal}, 64'd0);
    check("mid_ready", {63'd0, inj_ready}, 64'd0);
    check("mid_ejvalid", {63'd0, ej_valid}, 64'd0);
    check("mid_drop", {63'd0, ej_drop}, 64'd0);
    check("mid_cnt", {56'd0, drop_cnt}, 64'd0);
    doutLocal = 64'h8000_0000_0000_0400;
    tick(1);
    check("mid_ready2", {63'd0, inj_ready}, 64'd0);
    check("mid_ejvalid2", {63'd0, ej_valid}, 64'd0);
    doutLocal = '0; inj_valid = 1'b0; link_vld = 4'b0000;
    reset = 1'b1;
    tick(1);
    check("rel_ready", {63'd0, inj_ready}, 64'd1);
    tick(3);
    check("rel_din", dinLocal, 64'd0);
    check("rel_ejvalid", {63'd0, ej_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/local_ni.md
LOCAL_NI -- requirements
Module: local_ni

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH_PORT, 64, flit width.
- WIDTH_PV, 5, productive-vector width.
- POS_VALID, 63, flit valid bit index.
- POS_X_LSB, 0, LSB of the 3-bit destination X field.
- POS_Y_LSB, 3, LSB of the 3-bit destination Y field.
- CORD_X, 0, this router's X coordinate.
- CORD_Y, 0, this router's Y coordinate.
- INJ_DEPTH, 4, injection FIFO entries.
- EJ_DEPTH, 4, ejection FIFO entries.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on the rising edge.
- reset, in, 1, synchronous active-low reset.
- inj_valid, in, 1, core offers a flit.
- inj_data, in, WIDTH_PORT, core flit.
- inj_ready, out, 1, injection FIFO not full.
- link_vld, in, 4, valid bits of router inputs {W,S,E,N} in the current cycle.
- dinLocal, out, WIDTH_PORT, flit to router local input.
- PVLocal, out, WIDTH_PV, productive vector for dinLocal.
- doutLocal, in, WIDTH_PORT, ejected flit from router.
- ej_valid, out, 1, ejection FIFO non-empty.
- ej_data, out, WIDTH_PORT, head of ejection FIFO.
- ej_ready, in, 1, core accepts ej_data.
- ej_drop, out, 1, one-cycle pulse when an ejected flit is lost.
- drop_cnt, out, 8, saturating count of dropped flits.

Function
REQ-003 Injection push: when inj_valid && inj_ready at a clock edge, inj_data SHALL be written to the injection FIFO.
REQ-004 inj_ready SHALL equal NOT injection-FIFO-full, with no combinational path from any input.
REQ-005 Slot-free condition: slot_free = (link_vld != 4'b1111).
REQ-006 Injection pop: at each edge where the FIFO is non-empty and slot_free, the head SHALL be popped.
- dinLocal is registered with the head, with bit POS_VALID forced to 1.
- PVLocal is registered with the XY vector of the head.
REQ-007 When no pop occurs, dinLocal and PVLocal SHALL register all zeros, so each injected flit is valid for exactly one cycle.
REQ-008 XY productive vector, bit order [0]=N, [1]=E, [2]=S, [3]=W, [4]=local:
- dstX > CORD_X: E.
- dstX < CORD_X: W.
- dstX equal and dstY > CORD_Y: N.
- dstX equal and dstY < CORD_Y: S.
- both equal: local (5'b10000).
- Exactly one bit is set.
REQ-009 Latency and ordering:
- Minimum latency from push edge to dinLocal valid is one cycle (the next edge).
- Flits leave in FIFO order.
- Pushing into an empty FIFO while slot_free is low SHALL hold the flit.
REQ-010 When the injection FIFO is full, push is blocked (inj_ready=0), even if a pop occurs in the same cycle.
REQ-011 Ejection push: at each edge where doutLocal[POS_VALID]=1, doutLocal SHALL be written to the ejection FIFO, unless the FIFO is full and no pop occurs in that cycle.
REQ-012 Ejection pop: ej_valid = non-empty; ej_data = head; the head is popped when ej_valid && ej_ready.
REQ-013 Full with simultaneous pop and push: both SHALL occur and occupancy is unchanged.
REQ-014 Drop: if a valid flit arrives while the ejection FIFO is full and no pop occurs:
- the flit SHALL be discarded;
- ej_drop is registered high for the following cycle only;
- drop_cnt increments, saturating at 255.
REQ-015 FIFO pointers SHALL wrap modulo depth. Full/empty SHALL be distinguished by an occupancy counter of width clog2(depth)+1.

Reset
REQ-016 While reset=0 at an edge, the following SHALL clear on that edge:
- both FIFOs empty;
- dinLocal=0, PVLocal=0, ej_drop=0, drop_cnt=0.
REQ-017 Reset asserted mid-operation SHALL discard all buffered flits, and no output may carry a stale flit in the cycle after reset.
REQ-018 During reset, inj_ready=0 and ej_valid=0. Pushes and arrivals in reset cycles are ignored.

Verification
REQ-019 Single injection: CORD=(0,0); push flit dst (2,1) with link_vld=4'b0000 -> next cycle dinLocal valid, PVLocal=5'b00010, then zeros.
REQ-020 Blocked slots: link_vld=4'b1111 for 5 cycles with 4 flits pushed -> inj_ready=0 after the 4th push, no dinLocal. Drop link_vld to 4'b0111 -> four flits emitted in order on consecutive cycles.
REQ-021 XY coverage: dst (0,3), (0,0), (0,-) mirrored with CORD=(3,3) -> PVLocal N/local/S/W as in REQ-008.
REQ-022 Ejection overflow: ej_ready=0, 6 consecutive valid doutLocal -> 4 stored, ej_drop high 2 cycles, drop_cnt=2. Full plus simultaneous pop and arrival -> no drop.
REQ-023 Saturation: 300 drops -> drop_cnt=255.
REQ-024 Reset mid-stream: assert reset with 3 flits queued in each FIFO -> after the reset edge, all outputs zero, inj_ready low until release, then both FIFOs empty.
